// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared types, segment encodings and helpers for the scanned display
package seg_display_pkg;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam int DIG_ONES     = 0;
  localparam int DIG_TENS     = 1;
  localparam int DIG_HUNDREDS = 2;
  localparam int DIG_SIGN     = 3;
  // Active-high {g,f,e,d,c,b,a}; out-of-range nibbles render blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
  // Double-dabble correction for one BCD nibble.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg_bcd_shift.sv
// seg_bcd_shift: iterative 8-bit binary to 3-digit BCD converter, one shift per clock
module seg_bcd_shift
  import seg_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [19:0] sr;
  logic [19:0] adj;
  logic [2:0]  cnt;
  logic        active;
  // done marks the cycle whose closing edge performs the eighth and final shift.
  assign done = active && cnt == 3'd7;
  assign bcd  = sr[19:8];
  assign adj  = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
  // Load on start, then correct-and-shift once per cycle for eight cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sr     <= {12'd0, bin};
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      sr     <= {adj[18:0], 1'b0};
      cnt    <= cnt + 3'd1;
      active <= !done;
    end
  end
endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: handshake-loaded BCD conversion with a scanned 4-digit 7-segment output
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  input  logic       load_signed,
  output logic [6:0] seg,
  output logic [3:0] digit_en,
  output logic       busy
);
  localparam int             DW      = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0]  DIV_MAX = DW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  state_t        state, state_n;
  logic          accept, neg_in, neg_q, conv_done;
  logic [7:0]    mag;
  logic [11:0]   bcd, disp, disp_n;
  logic          disp_neg, disp_neg_n;
  logic [DW-1:0] div;
  logic          wrap;
  logic [3:0]    en_n, hun, ten, one;
  logic [6:0]    seg_n;
  assign accept = load_valid && load_ready;
  assign neg_in = load_signed && load_data[7];
  assign mag    = neg_in ? 8'(~load_data + 8'd1) : load_data;
  seg_bcd_shift u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );
  // FSM next state and handshake/busy outputs.
  always_comb begin
    state_n    = state;
    load_ready = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        busy       = 1'b0;
        if (load_valid) state_n = CONV;
      end
      CONV:    if (conv_done) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  // Shadow values as they will be after this edge, so a commit shows up on seg at once.
  assign {disp_neg_n, disp_n} = (state == COMMIT) ? {neg_q, bcd} : {disp_neg, disp};
  assign {hun, ten, one}      = disp_n;
  // Capture the sign at accept and publish it with the digits at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q    <= 1'b0;
      disp     <= '0;
      disp_neg <= 1'b0;
    end else begin
      if (accept) neg_q <= neg_in;
      disp     <= disp_n;
      disp_neg <= disp_neg_n;
    end
  end
  // Scan rotation; a cleared digit_en (post-reset) starts at the ones digit.
  assign wrap = div == DIV_MAX;
  assign en_n = (digit_en == 4'd0) ? 4'b0001 :
                wrap ? {digit_en[2:0], digit_en[3]} : digit_en;
  // Segment pattern for the digit enabled after this edge, with leading-zero blanking.
  assign seg_n = en_n[DIG_ONES]     ? seg_decode(one) :
                 en_n[DIG_TENS]     ? ((hun == 4'd0 && ten == 4'd0) ? SEG_BLANK : seg_decode(ten)) :
                 en_n[DIG_HUNDREDS] ? ((hun == 4'd0) ? SEG_BLANK : seg_decode(hun)) :
                 en_n[DIG_SIGN]     ? (disp_neg_n ? SEG_MINUS : SEG_BLANK) : SEG_BLANK;
  // Divider, digit select and polarity-adjusted segment register update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      digit_en <= '0;
      seg      <= SEG_OFF;
    end else begin
      div      <= wrap ? '0 : div + 1'b1;
      digit_en <= en_n;
      seg      <= SEG_ACTIVE_LOW ? ~seg_n : seg_n;
    end
  end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: table-driven check of conversion, blanking, scan and corner sequences
module tb_seg_display_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, load_valid = 1'b0, load_signed = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       ready_a, busy_a, ready_b, busy_b;
  logic [6:0] seg_a, seg_b;
  logic [3:0] en_a, en_b;
  int         nvec = 0, nerr = 0;
  typedef struct {
    logic [7:0] data;
    logic       sgn;
    logic [6:0] s, h, t, o;
  } vec_t;
  vec_t tbl[8];
  vec_t newv, zero;
  always #5 clk = ~clk;
  seg_display_ctrl #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_a),
    .load_data(load_data), .load_signed(load_signed), .seg(seg_a), .digit_en(en_a), .busy(busy_a)
  );
  seg_display_ctrl #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_b),
    .load_data(load_data), .load_signed(load_signed), .seg(seg_b), .digit_en(en_b), .busy(busy_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] exp_for(input vec_t v, input logic [3:0] en);
    return en == 4'b0001 ? v.o : en == 4'b0010 ? v.t : en == 4'b0100 ? v.h :
           en == 4'b1000 ? v.s : 7'h00;
  endfunction
  task automatic scan(input vec_t v, input int cycles);
    logic [6:0] e, ei;
    repeat (cycles) begin
      @(negedge clk);
      e  = exp_for(v, en_a);
      ei = ~e;
      chk("onehot", 32'($onehot(en_a)), 1);
      chk("en_match", en_b, en_a);
      chk("seg_high", seg_b, e);
      chk("seg_low", seg_a, ei);
      chk("idle", busy_a, 0);
    end
  endtask
  task automatic load(input vec_t v, output int bc);
    int n = 0;
    while (!ready_a && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", ready_a, 1);
    load_valid = 1'b1; load_data = v.data; load_signed = v.sgn;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    bc = 0;
    while (busy_a && bc < 50) begin bc++; @(negedge clk); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int bc, n;
    logic [3:0] v;
    logic [6:0] e;
    tbl[0] = '{8'hFF, 1'b0, 7'h00, 7'h5B, 7'h6D, 7'h6D};
    tbl[1] = '{8'h80, 1'b1, 7'h40, 7'h06, 7'h5B, 7'h7F};
    tbl[2] = '{8'hFF, 1'b1, 7'h40, 7'h00, 7'h00, 7'h06};
    tbl[3] = '{8'h7F, 1'b1, 7'h00, 7'h06, 7'h5B, 7'h07};
    tbl[4] = '{8'h00, 1'b0, 7'h00, 7'h00, 7'h00, 7'h3F};
    tbl[5] = '{8'h0A, 1'b0, 7'h00, 7'h00, 7'h06, 7'h3F};
    tbl[6] = '{8'h64, 1'b0, 7'h00, 7'h06, 7'h3F, 7'h3F};
    tbl[7] = '{8'h9C, 1'b1, 7'h40, 7'h06, 7'h3F, 7'h3F};
    newv   = '{8'h2A, 1'b0, 7'h00, 7'h00, 7'h66, 7'h5B};
    zero   = tbl[4];
    repeat (2) @(negedge clk);
    chk("rst_en", en_a, 0);
    chk("rst_seg_low", seg_a, 7'h7F);
    chk("rst_seg_high", seg_b, 7'h00);
    chk("rst_ready", ready_a, 1);
    chk("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_en", en_a, 4'b0001);
    chk("first_seg_low", seg_a, 7'h40);
    chk("first_seg_high", seg_b, 7'h3F);
    n = 0;
    while (en_a == 4'b0001 && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      v = en_a;
      n = 0;
      while (en_a == v && n < 20) begin n++; @(negedge clk); end
      chk("rot_period", n, 4);
      chk("rot_next", en_a, {v[2:0], v[3]});
    end
    for (int i = 0; i < 8; i++) begin
      load(tbl[i], bc);
      chk("busy_cycles", bc, 9);
      scan(tbl[i], 18);
    end
    load_valid = 1'b1; load_data = newv.data; load_signed = newv.sgn;
    @(posedge clk);
    repeat (8) begin
      @(negedge clk);
      load_data = 8'h63; load_signed = 1'b1;
      e = exp_for(tbl[7], en_a);
      chk("held_not_ready", ready_a, 0);
      chk("old_held", seg_b, e);
    end
    load_valid = 1'b0;
    n = 0;
    while (!ready_a && n < 20) begin @(negedge clk); n++; end
    chk("ready_after_commit", ready_a, 1);
    scan(newv, 18);
    load_valid = 1'b1; load_data = 8'hFF; load_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", en_a, 0);
    chk("midrst_seg_low", seg_a, 7'h7F);
    chk("midrst_seg_high", seg_b, 7'h00);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ready", ready_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    scan(zero, 20);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Sequential controller for the 3-digit-plus-sign 7-segment display. It accepts an 8-bit value through a valid/ready handshake and converts it to BCD with an iterative shift-add-3 engine, one shift per clock. It time-multiplexes the ones, tens, hundreds and sign digits onto one shared segment bus. It sits between the CPU result register and the board display, and replaces per-digit combinational decoding with one scanned output.

## Interface
- REFRESH_DIV, 1000: clock cycles each digit stays enabled; legal range ≥ 2.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0; 0 = lit when 1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load_data/load_signed valid this cycle.
- load_ready  out  1  controller can accept a load.
- load_data  in  8  value to display.
- load_signed  in  1  1 = load_data is two's complement.
- seg  out  7  {g,f,e,d,c,b,a} for the enabled digit, polarity per SEG_ACTIVE_LOW.
- digit_en  out  4  one-hot, active-high digit select: bit0 ones, bit1 tens, bit2 hundreds, bit3 sign.
- busy  out  1  conversion in progress.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- IDLE: load_ready=1. A load is accepted when load_valid && load_ready. On accept, magnitude = (load_signed && load_data[7]) ? -load_data : load_data, computed in 8 bits, so 0x80 gives 128. neg = load_signed && load_data[7]. The shift register is set to {12'd0, magnitude}, the iteration counter to 0, and the FSM goes to CONV.
- CONV: each cycle, add 3 to every BCD nibble (hundreds, tens, ones) that is ≥ 5, then shift left 1 and increment the counter. After the 8th shift, go to COMMIT. load_ready=0 and busy=1 throughout.
- COMMIT: copy the BCD nibbles and neg into the display shadow registers, then return to IDLE. busy=1, load_ready=0.
- load_valid while not ready is ignored and not queued.
- The display always shows the shadow registers. The old value stays visible for the whole conversion.
- Leading-zero blanking:
  - hundreds is blank if 0;
  - tens is blank if hundreds and tens are both 0;
  - ones always shows.
- Sign digit shows segment g only when neg is set, otherwise blank.
- Digits 0-9 use standard encodings. Nibbles > 9 cannot occur; decode them as blank.
- Scan: a divider counts 0..REFRESH_DIV-1. On wrap, digit_en rotates 0001→0010→0100→1000→0001. The scan runs independently of the FSM.

## Timing
- Reset values:
  - FSM IDLE, load_ready=1, busy=0;
  - shadow digits 0, neg=0;
  - digit_en=0000, seg=all off (7'h7F if SEG_ACTIVE_LOW, else 7'h00);
  - divider 0.
- On the first clock after reset release, digit_en=0001 and seg shows '0'.
- seg and digit_en are registered and change on the same edge. seg always matches the digit currently enabled.
- Latency: accept at edge N → CONV edges N+1..N+8 → COMMIT edge N+9. The new digits appear on seg from edge N+10 whenever their digit is enabled. load_ready is 1 again from edge N+10.
- Back-to-back loads: minimum spacing is 10 cycles.
- Reset asserted mid-conversion: all state returns to reset values immediately. The partial result is discarded and never committed.
- A commit on the same edge as a scan rotation is legal. The newly enabled digit shows the new value.

## Structure
- Package seg_display_pkg:
  - FSM state enum;
  - 7-bit segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK (active-high form);
  - digit index constants DIG_ONES, DIG_TENS, DIG_HUNDREDS, DIG_SIGN.
- Polarity inversion is applied once, at the seg output register.
- One sub-module, seg_bcd_shift: the iterative double-dabble core with start, done and a 12-bit bcd output. The FSM, shadow registers, blanking and scan stay in seg_display_ctrl.

## Test plan
- load 0xFF, load_signed=0 → after 10 cycles, scanned digits read 2,5,5 and sign blank. busy is high for exactly 9 cycles.
- load 0x80, signed=1 → '-',1,2,8. Load 0xFF, signed=1 → '-', blank, blank, 1.
- load 0x7F, signed=1 → 1,2,7, sign blank. Load 0x00 → hundreds and tens blank, ones '0'.
- REFRESH_DIV=4 → digit_en rotates every 4 cycles, 0001→…→1000→0001 wraps. Both SEG_ACTIVE_LOW values give complementary seg.
- load_valid held during CONV with a second value → ignored (load_ready=0). Display holds the old value until commit, then shows the first value only.
- rst_n pulsed low at CONV cycle 4 → immediate reset values. The shadow stays 0 (ones '0') and no commit occurs.
